// File: rtl/mux2_arb_if.sv
// mux2_arb_if
// -----------------------------------------------------------------------------
// Bundles the signals between the two requesters, the mux2_arb arbiter and the
// downstream consumer of the shared 2:1 datapath. The clock and reset stay
// plain ports on the arbiter.
//
// Parameters:
//   dw         data width of each requester and of the registered output
//
// Signals:
//   req_0/1    requester has a beat to send, held until accepted
//   data_0/1   requester data, valid while the matching req is high
//   gnt_0/1    registered ownership of the shared path
//   ack_0/1    combinational beat-accepted strobes
//   select     registered mux select (current or last owner)
//   out_data   registered accepted beat
//   out_src    registered source of out_data
//   out_valid  out_data holds a beat not yet consumed
//   out_ready  consumer takes out_data when out_valid && out_ready
//
// Modports:
//   master     the requester/consumer side (drives req, data, out_ready)
//   slave      the arbiter side (drives grants, acks, select and output stage)
// -----------------------------------------------------------------------------
interface mux2_arb_if #(
  parameter int dw = 8
);

  logic          req_0;
  logic          req_1;
  logic [dw-1:0] data_0;
  logic [dw-1:0] data_1;
  logic          gnt_0;
  logic          gnt_1;
  logic          ack_0;
  logic          ack_1;
  logic          select;
  logic [dw-1:0] out_data;
  logic          out_src;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output req_0,
    output req_1,
    output data_0,
    output data_1,
    output out_ready,
    input  gnt_0,
    input  gnt_1,
    input  ack_0,
    input  ack_1,
    input  select,
    input  out_data,
    input  out_src,
    input  out_valid
  );

  modport slave (
    input  req_0,
    input  req_1,
    input  data_0,
    input  data_1,
    input  out_ready,
    output gnt_0,
    output gnt_1,
    output ack_0,
    output ack_1,
    output select,
    output out_data,
    output out_src,
    output out_valid
  );

endinterface

// File: rtl/mux2_arb.sv
// mux2_arb
// -----------------------------------------------------------------------------
// Two-requester round-robin arbiter with a registered output stage, owning the
// select of the shared 2:1 datapath mux in the brisc core. One requester owns
// the path at a time; while the other side is waiting, an owner may only have
// max_burst consecutive beats accepted before ownership rotates. Accepted
// beats are registered into a one-entry output slot with a valid/ready
// handshake toward the consumer.
//
// Parameters:
//   dw         data width (must match the interface instance)
//   max_burst  consecutive accepted beats per grant under contention, 1..16
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        mux2_arb_if slave modport (requests, grants, acks, select,
//              registered output stage and consumer ready)
// -----------------------------------------------------------------------------
module mux2_arb #(
  parameter int dw        = 8,
  parameter int max_burst = 4
) (
  input logic         clk,
  input logic         reset_n,
  mux2_arb_if.slave   bus
);

  localparam int cw = $clog2(max_burst + 1);
  localparam logic [cw-1:0] max_cnt = cw'(max_burst);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          last;
  logic          last_nx;
  logic [cw-1:0] beat_cnt;
  logic [cw-1:0] cnt_nx;
  logic [cw-1:0] cnt_inc;

  logic          gnt_0_q;
  logic          gnt_1_q;
  logic          select_q;
  logic [dw-1:0] out_data_q;
  logic          out_src_q;
  logic          out_valid_q;

  logic          slot_free;
  logic          ack_0_c;
  logic          ack_1_c;
  logic          accept;

  // The output slot can take a new beat when it is empty or being drained in
  // this same cycle, which is what allows one beat per cycle with ready high.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    ack_0_c   = gnt_0_q && bus.req_0 && slot_free;
    ack_1_c   = gnt_1_q && bus.req_1 && slot_free;
    accept    = ack_0_c || ack_1_c;
    cnt_inc   = beat_cnt + 1'b1;
  end

  // Ownership decision. An owner that drops its request hands over
  // immediately (or falls back to IDLE); an owner whose accepted beat fills
  // the burst quota rotates only if the other side is waiting, otherwise it
  // keeps the path and simply restarts its count. Any change of owner is a
  // fresh grant, so the round-robin pointer and the beat count follow it.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = beat_cnt;

    case (state)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          state_nx = last ? OWN0 : OWN1;
        end else if (bus.req_0) begin
          state_nx = OWN0;
        end else if (bus.req_1) begin
          state_nx = OWN1;
        end
      end

      OWN0: begin
        if (!bus.req_0) begin
          state_nx = bus.req_1 ? OWN1 : IDLE;
        end else if (ack_0_c) begin
          if (cnt_inc == max_cnt) begin
            if (bus.req_1) begin
              state_nx = OWN1;
            end else begin
              cnt_nx = '0;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end

      OWN1: begin
        if (!bus.req_1) begin
          state_nx = bus.req_0 ? OWN0 : IDLE;
        end else if (ack_1_c) begin
          if (cnt_inc == max_cnt) begin
            if (bus.req_0) begin
              state_nx = OWN0;
            end else begin
              cnt_nx = '0;
            end
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if ((state_nx != state) && (state_nx != IDLE)) begin
      last_nx = (state_nx == OWN1);
      cnt_nx  = '0;
    end else if (state_nx == IDLE) begin
      cnt_nx = '0;
    end
  end

  // Arbitration state. Grants and select are registered copies of the next
  // owner so the datapath mux sees a clean flop output; in IDLE the select
  // keeps pointing at whoever owned the path last. last resets to 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      beat_cnt <= '0;
      gnt_0_q  <= 1'b0;
      gnt_1_q  <= 1'b0;
      select_q <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      beat_cnt <= cnt_nx;
      gnt_0_q  <= (state_nx == OWN0);
      gnt_1_q  <= (state_nx == OWN1);
      if (state_nx != IDLE) begin
        select_q <= (state_nx == OWN1);
      end
    end
  end

  // Output slot. A new accept always wins, so a drain and an accept on the
  // same edge replace the beat and keep out_valid high; a drain alone empties
  // the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_data_q  <= ack_1_c ? bus.data_1 : bus.data_0;
      out_src_q   <= ack_1_c;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.gnt_0     = gnt_0_q;
  assign bus.gnt_1     = gnt_1_q;
  assign bus.ack_0     = ack_0_c;
  assign bus.ack_1     = ack_1_c;
  assign bus.select    = select_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule
